// File: rtl/huxiled4_sched.sv
// Round-robin scheduler that hands one shared breathing engine to four LEDs in turn.
// Optional breath watchdog is compiled in with macro HUXILED4_SCHED_TIMEOUT_EN.
module huxiled4_sched #(
  parameter int GAP_CYC     = 12500000,
  parameter int TIMEOUT_CYC = 75000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic [3:0] mask,
  input  logic       breath_done,
  output logic       breath_start,
  output logic [3:0] led_sel,
  output logic       busy,
  output logic [7:0] round_cnt,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int CW = 32;
  // A zero-length gap is not representable; it degrades to a single dark cycle.
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYC > 1) ? CW'(GAP_CYC - 1) : {CW{1'b0}};

  // First participating LED starting at cand and walking in the requested direction.
  function automatic logic [1:0] first_set(input logic [3:0] m, input logic [1:0] cand,
                                           input logic d);
    logic [1:0] pos;
    first_set = cand;
    for (int k = 3; k >= 0; k--) begin
      pos = d ? (cand - 2'(k)) : (cand + 2'(k));
      if (m[pos]) begin
        first_set = pos;
      end else begin
        first_set = first_set;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    idx_r, idx_s;
  logic [1:0]    cand_r, cand_s;
  logic          dir_r, dir_s;
  logic          first_r, first_s;
  logic [7:0]    round_r, round_s;
  logic [CW-1:0] gap_cnt_r;
  logic [1:0]    pick_s;
  logic          wrap_s;
  logic          breath_start_r;
  logic [3:0]    led_sel_r;
  logic          busy_r;

`ifdef HUXILED4_SCHED_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC > 1) ? CW'(TIMEOUT_CYC - 1) : {CW{1'b0}};
  logic          err_r, err_s;
  logic [CW-1:0] wd_cnt_r;
`endif

  assign pick_s = first_set(mask, cand_r, dir);
  // A pick at or behind the previous LED (in travel order) means a round has closed.
  assign wrap_s = dir ? (pick_s >= idx_r) : (pick_s <= idx_r);

  // Next-state and bookkeeping decisions.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cand_s  = cand_r;
    dir_s   = dir_r;
    first_s = first_r;
    round_s = round_r;
`ifdef HUXILED4_SCHED_TIMEOUT_EN
    err_s   = err_r;
`endif
    case (state_r)
      IDLE: begin
        if (en && (mask != 4'b0000)) begin
          cand_s  = dir ? 2'd3 : 2'd0;
          first_s = 1'b1;
          state_s = PICK;
        end else begin
          state_s = IDLE;
        end
      end
      PICK: begin
        if (!en || (mask == 4'b0000)) begin
          state_s = IDLE;
        end else begin
          idx_s   = pick_s;
          dir_s   = dir;
          first_s = 1'b0;
          if (!first_r && wrap_s) begin
            round_s = round_r + 8'd1;
          end else begin
            round_s = round_r;
          end
          state_s = START;
        end
      end
      START: begin
        state_s = RUN;
      end
      RUN: begin
        if (breath_done) begin
          state_s = GAP;
        end
`ifdef HUXILED4_SCHED_TIMEOUT_EN
        else if (wd_cnt_r >= TO_LAST) begin
          err_s   = 1'b1;
          state_s = GAP;
        end
`endif
        else begin
          state_s = RUN;
        end
      end
      GAP: begin
        if (gap_cnt_r >= GAP_LAST) begin
          cand_s  = dir_r ? (idx_r - 2'd1) : (idx_r + 2'd1);
          state_s = PICK;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and scheduling registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      cand_r  <= 2'd0;
      dir_r   <= 1'b0;
      first_r <= 1'b0;
      round_r <= 8'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cand_r  <= cand_s;
      dir_r   <= dir_s;
      first_r <= first_s;
      round_r <= round_s;
    end
  end

  // Gap timer restarts on every state entry and only advances while dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_r <= {CW{1'b0}};
    end else if (state_s != state_r) begin
      gap_cnt_r <= {CW{1'b0}};
    end else if (state_r == GAP) begin
      gap_cnt_r <= gap_cnt_r + CW'(1);
    end else begin
      gap_cnt_r <= gap_cnt_r;
    end
  end

`ifdef HUXILED4_SCHED_TIMEOUT_EN
  // Breath watchdog: counts RUN cycles; err is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r <= {CW{1'b0}};
      err_r    <= 1'b0;
    end else begin
      err_r <= err_s;
      if (state_s != state_r) begin
        wd_cnt_r <= {CW{1'b0}};
      end else if (state_r == RUN) begin
        wd_cnt_r <= wd_cnt_r + CW'(1);
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breath_start_r <= 1'b0;
      led_sel_r      <= 4'b0000;
      busy_r         <= 1'b0;
    end else begin
      breath_start_r <= (state_s == START);
      led_sel_r      <= ((state_s == START) || (state_s == RUN)) ? onehot(idx_s) : 4'b0000;
      busy_r         <= (state_s != IDLE);
    end
  end

  assign breath_start = breath_start_r;
  assign led_sel      = led_sel_r;
  assign busy         = busy_r;
  assign round_cnt    = round_r;

endmodule

// File: tb/tb_huxiled4_sched.sv
// Directed bench for huxiled4_sched with a behavioural rotation model and a simple breathing-engine model.
// Watchdog expectations follow macro HUXILED4_SCHED_TIMEOUT_EN.
module tb_huxiled4_sched;
  localparam int GAP = 4;
  localparam int TO  = 20;
  localparam int ENG = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic       breath_done = 1'b0;
  logic       breath_start;
  logic [3:0] led_sel;
  logic       busy;
  logic [7:0] round_cnt;
  logic       err;

  huxiled4_sched #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mask(mask), .breath_done(breath_done),
    .breath_start(breath_start), .led_sel(led_sel), .busy(busy), .round_cnt(round_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  logic [3:0] starts[$];
  logic [7:0] rounds_q[$];
  bit withhold = 1'b0;
  bit inject_bd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: breath_done arrives ENG cycles after breath_start unless withheld.
  initial begin
    int eng_cnt;
    eng_cnt = 0;
    forever begin
      @(posedge clk);
      #3;
      breath_done = 1'b0;
      if (rst) eng_cnt = 0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) breath_done = 1'b1;
      end
      if (inject_bd) breath_done = 1'b1;
      if (breath_start === 1'b1 && !withhold) eng_cnt = ENG;
    end
  end

  // Behavioural model: which LED is lit, for how long, and when rounds close.
  localparam int S_OFF = 0, S_CHOOSE = 1, S_FIRE = 2, S_LIT = 3, S_DARK = 4;
  initial begin
    int seg, cur, cand, left, lit_cycles, n;
    int rounds;
    bit first, mdir, merr;
    logic [3:0] e_led;
    seg = S_OFF; cur = 0; cand = 0; left = 0; lit_cycles = 0; rounds = 0;
    first = 1'b0; mdir = 1'b0; merr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seg = S_OFF; cur = 0; cand = 0; rounds = 0; merr = 1'b0; first = 1'b0; mdir = 1'b0;
      end
      e_led = (seg == S_FIRE || seg == S_LIT) ? 4'(1 << cur) : 4'b0000;
      check("led_sel", led_sel, e_led);
      check("breath_start", breath_start, (seg == S_FIRE));
      check("busy", busy, (seg != S_OFF));
      check("round_cnt", round_cnt, rounds % 256);
      check("err", err, merr);
      if (breath_start === 1'b1) begin
        starts.push_back(led_sel);
        rounds_q.push_back(round_cnt);
        last_start_cyc = cyc;
      end
      if (!rst) begin
        case (seg)
          S_OFF: if (en && mask != 4'b0000) begin
            cand = dir ? 3 : 0; first = 1'b1; seg = S_CHOOSE;
          end
          S_CHOOSE: if (!en || mask == 4'b0000) seg = S_OFF;
          else begin
            n = cand;
            for (int s = 0; s < 4; s++) begin
              int i;
              i = dir ? (cand - s + 4) % 4 : (cand + s) % 4;
              if (mask[i]) begin n = i; break; end
            end
            if (!first && (dir ? (n >= cur) : (n <= cur))) rounds++;
            first = 1'b0; cur = n; mdir = dir; seg = S_FIRE;
          end
          S_FIRE: begin seg = S_LIT; lit_cycles = 0; end
          S_LIT: begin
            lit_cycles++;
            if (breath_done) begin seg = S_DARK; left = GAP; end
`ifdef HUXILED4_SCHED_TIMEOUT_EN
            else if (lit_cycles == TO) begin merr = 1'b1; seg = S_DARK; left = GAP; end
`endif
          end
          S_DARK: begin
            left--;
            if (left == 0) begin cand = mdir ? (cur + 3) % 4 : (cur + 1) % 4; seg = S_CHOOSE; end
          end
          default: seg = S_OFF;
        endcase
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_starts(input string name, input int n, input int budget);
    int b;
    b = 0;
    while (starts.size() < n && b < budget) begin step(1); b++; end
    check(name, starts.size(), n);
  endtask

  task automatic do_reset(input logic e, input logic d, input logic [3:0] m);
    rst = 1'b1;
    step(2);
    starts.delete();
    rounds_q.delete();
    en = e; dir = d; mask = m;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp1[5];
    logic [3:0] exp2[3];
    int b, t_fall, rel_cyc;
    exp1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp2 = '{4'b1000, 4'b0010, 4'b1000};

    step(3);
    check("reset_led_sel", led_sel, 4'b0000);
    check("reset_busy", busy, 1'b0);
    check("reset_round", round_cnt, 8'd0);

    // Full mask, forward rotation.
    do_reset(1'b1, 1'b0, 4'b1111);
    wait_starts("t1_count", 5, 150);
    for (int i = 0; i < 5; i++) check($sformatf("t1_led%0d", i), starts[i], exp1[i]);
    check("t1_round_before_wrap", rounds_q[3], 8'd0);
    check("t1_round_at_wrap", rounds_q[4], 8'd1);

    // Sparse mask, reverse rotation.
    do_reset(1'b1, 1'b1, 4'b1010);
    wait_starts("t2_count", 3, 100);
    for (int i = 0; i < 3; i++) check($sformatf("t2_led%0d", i), starts[i], exp2[i]);
    check("t2_round_mid", rounds_q[1], 8'd0);
    check("t2_round_wrap", rounds_q[2], 8'd1);

    // en dropped mid-RUN: breath + gap complete, then IDLE; stray breath_done ignored.
    do_reset(1'b1, 1'b0, 4'b1111);
    wait_starts("t3_count", 1, 20);
    step(3);
    en = 1'b0;
    b = 0;
    while (busy !== 1'b0 && b < 40) begin step(1); b++; end
    t_fall = cyc;
    check("t3_idle_delay", t_fall - last_start_cyc, 16);
    inject_bd = 1'b1;
    step(1);
    inject_bd = 1'b0;
    step(5);
    check("t3_no_restart", starts.size(), 1);
    check("t3_idle_busy", busy, 1'b0);

    // Engine withholds breath_done.
    withhold = 1'b1;
    do_reset(1'b1, 1'b0, 4'b0011);
    wait_starts("t4_count", 1, 20);
    step(30);
`ifdef HUXILED4_SCHED_TIMEOUT_EN
    check("t4_err", err, 1'b1);
    check("t4_advanced", starts.size(), 2);
    check("t4_next_led", starts[1], 4'b0010);
`else
    check("t4_err", err, 1'b0);
    check("t4_still_busy", busy, 1'b1);
    check("t4_still_lit", led_sel, 4'b0001);
    check("t4_no_advance", starts.size(), 1);
`endif
    withhold = 1'b0;

    // Reset during RUN.
    do_reset(1'b1, 1'b0, 4'b1111);
    wait_starts("t5_count", 5, 150);
    step(3);
    check("t5_pre_round", round_cnt, 8'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_led", led_sel, 4'b0000);
    check("t5_rst_round", round_cnt, 8'd0);
    check("t5_rst_busy", busy, 1'b0);
    step(2);
    starts.delete();
    rounds_q.delete();
    rst = 1'b0;
    rel_cyc = cyc;
    wait_starts("t5_restart", 1, 20);
    check("t5_first_led", starts[0], 4'b0001);
    check("t5_start_latency", last_start_cyc - rel_cyc, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/huxiled4_sched.md
HUXILED4_SCHED -- requirements
Module: huxiled4_sched

Interface
REQ-001 The block SHALL have parameter GAP_CYC, default 12500000, giving the dark gap between breaths in clk cycles (0.5 s at 25 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 75000000, giving the breath watchdog limit in clk cycles (3 s at 25 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: 25 MHz system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: run enable, level-sensitive.
REQ-006 The block SHALL have port dir, input, 1 bit: rotation direction; 0 means LED0 toward LED3, 1 means LED3 toward LED0.
REQ-007 The block SHALL have port mask, input, 4 bits: a 1 marks that LED as participating.
REQ-008 The block SHALL have port breath_done, input, 1 bit: one-cycle pulse from the shared breathing engine at the end of a full up/down breath.
REQ-009 The block SHALL have port breath_start, output, 1 bit: one-cycle pulse that starts the engine.
REQ-010 The block SHALL have port led_sel, output, 4 bits: one-hot route of the engine PWM to the selected LED; all zeros when no LED is selected.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port round_cnt, output, 8 bits: count of completed rotation rounds, wrapping.
REQ-013 The block SHALL have port err, output, 1 bit: sticky watchdog flag.

Function
REQ-014 The FSM SHALL have states IDLE, PICK, START, RUN and GAP, all registered.
REQ-015 IDLE: when en=1 and mask!=0, the FSM SHALL set the search candidate to 0 (dir=0) or 3 (dir=1) and go to PICK; otherwise it SHALL stay in IDLE.
REQ-016 PICK: if en=0 or mask=0 the FSM SHALL go to IDLE; otherwise, in one cycle, it SHALL select the first index with mask=1, searching from the candidate in dir order modulo 4, store it in idx, and go to START.
REQ-017 In PICK, round_cnt SHALL increment by 1 (mod 256) when the chosen idx is <= the previous idx (dir=0) or >= the previous idx (dir=1); this rule does not apply to the first pick after leaving IDLE.
REQ-018 START: breath_start SHALL be 1 for exactly this cycle, led_sel SHALL equal onehot(idx), and the FSM SHALL go to RUN.
REQ-019 RUN: led_sel SHALL hold onehot(idx); on breath_done=1 the FSM SHALL go to GAP.
REQ-020 breath_done SHALL be ignored in every state other than RUN, including the START cycle.
REQ-021 GAP: led_sel SHALL be 0, and the FSM SHALL stay in GAP for exactly GAP_CYC cycles, then set candidate = idx+1 (dir=0) or idx-1 (dir=1) mod 4 and go to PICK.
REQ-022 en, dir and mask SHALL be sampled only in IDLE and PICK; a change mid-breath SHALL take effect at the next PICK.
REQ-023 Deasserting en during RUN or GAP SHALL NOT cut short the current breath or gap; the FSM SHALL return to IDLE at the following PICK.
REQ-024 The gap counter and the watchdog counter SHALL each be at least 27 bits wide and SHALL reset to 0 on every state entry.

Reset
REQ-025 While rst=1, the block SHALL immediately force state=IDLE, idx=0, candidate=0, led_sel=0, breath_start=0, busy=0, round_cnt=0, err=0 and all counters to 0, independent of clk.
REQ-026 A reset asserted mid-breath SHALL drop led_sel to 0 at once; after release the FSM SHALL restart from IDLE with no breath_start issued until PICK completes.

Configuration
REQ-027 With macro HUXILED4_SCHED_TIMEOUT_EN defined, in RUN the block SHALL count cycles and, on reaching TIMEOUT_CYC without breath_done, set err=1, abandon the breath and go to GAP; err SHALL be cleared only by rst.
REQ-028 Without HUXILED4_SCHED_TIMEOUT_EN, RUN SHALL wait indefinitely for breath_done, err SHALL be tied to 0, and no watchdog logic SHALL be present.

Verification (GAP_CYC=4, TIMEOUT_CYC=20, engine model returns breath_done 10 cycles after breath_start)
REQ-029 rst released, en=1, mask=4'b1111, dir=0: the bench SHALL see led_sel sequence 0001, 0010, 0100, 1000, 0001; each breath_start one cycle wide; round_cnt reaches 1 at the second 0001 PICK.
REQ-030 mask=4'b1010, dir=1: the bench SHALL see led_sel 1000, 0010, 1000, with round_cnt incrementing at the second 1000 pick; LEDs 0 and 2 are never selected.
REQ-031 en dropped mid-RUN: the breath SHALL complete, 4 GAP cycles SHALL follow, then IDLE with busy=0; breath_done injected during IDLE SHALL produce no response.
REQ-032 The engine SHALL be made to withhold breath_done. With the macro defined: 20 cycles after breath_start, err=1 and rotation continues to the next LED. Without the macro: the FSM stays in RUN and err=0.
REQ-033 rst pulsed during RUN: led_sel=0 and round_cnt=0 within the same cycle; after release, the first led_sel shall be onehot(0) for dir=0.
